// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data accesses.
// Data normally wins; a starvation counter lets a waiting fetch through, and stuck accesses time out.
module mem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int WAIT_MAX   = 15,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err
);

    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_DM = 2'd2
    } state_t;

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [STARVE_W-1:0] r_starve_cnt;

    logic w_dm_req;
    logic w_if_req;
    logic w_if_wins;
    logic w_timeout;
    logic w_starved;

    // A request whose own valid is pulsing has just been answered and must not be re-issued.
    assign w_dm_req  = (MemRead | MemWrite) & ~dm_valid;
    assign w_if_req  = if_req & ~if_valid;
    assign w_starved = (r_starve_cnt == STARVE_W'(STARVE_MAX));
    assign w_if_wins = w_if_req & (~w_dm_req | w_starved);
    assign w_timeout = (r_wait_cnt == WAIT_W'(WAIT_MAX - 1));

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = (MemRead | MemWrite) & ~dm_valid;

    // Arbitration FSM; every output it drives is registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rdata     <= '0;
            dm_rdata     <= '0;
            if_valid     <= 1'b0;
            dm_valid     <= 1'b0;
            err          <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The cycle carrying a valid pulse is the mandatory gap between grants.
                    if (!(if_valid || dm_valid)) begin
                        if (w_if_wins) begin
                            r_state      <= SERVE_IF;
                            mem_req      <= 1'b1;
                            mem_we       <= 1'b0;
                            mem_addr     <= if_addr;
                            mem_wdata    <= '0;
                            r_wait_cnt   <= '0;
                            r_starve_cnt <= '0;
                        end else if (w_dm_req) begin
                            r_state    <= SERVE_DM;
                            mem_req    <= 1'b1;
                            mem_we     <= MemWrite;
                            mem_addr   <= dm_addr;
                            mem_wdata  <= dm_wdata;
                            r_wait_cnt <= '0;
                            if (if_req && !w_starved) begin
                                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
                            end
                        end
                    end
                end
                SERVE_IF, SERVE_DM: begin
                    if (mem_ack) begin
                        r_state <= IDLE;
                        mem_req <= 1'b0;
                        if (r_state == SERVE_IF) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                            dm_valid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state    <= IDLE;
                        mem_req    <= 1'b0;
                        err        <= 1'b1;
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        if (r_state == SERVE_IF) begin
                            if_rdata <= '0;
                            if_valid <= 1'b1;
                        end else begin
                            dm_rdata <= '0;
                            dm_valid <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// timeout, reset-abort and read+write sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.DATA_W(32), .WAIT_MAX(15), .STARVE_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .MemRead(MemRead), .MemWrite(MemWrite), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        i_ifr, i_rd, i_wr, i_ack;
        logic [31:0] i_ifa, i_dma, i_wd, i_rdata;
        logic        e_req, e_we;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_ifd;
        logic        e_dmv;
        logic [31:0] e_dmd;
        logic        e_sif, e_smem;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic ifr, input logic rd, input logic wr, input logic ack,
        input logic [31:0] ifa, input logic [31:0] dma, input logic [31:0] wd,
        input logic [31:0] rdat,
        input logic req, input logic we, input logic [31:0] addr,
        input logic ifv, input logic [31:0] ifd, input logic dmv, input logic [31:0] dmd,
        input logic sif, input logic smem);
        vec_t v;
        v.i_ifr = ifr; v.i_rd = rd; v.i_wr = wr; v.i_ack = ack;
        v.i_ifa = ifa; v.i_dma = dma; v.i_wd = wd; v.i_rdata = rdat;
        v.e_req = req; v.e_we = we; v.e_addr = addr;
        v.e_ifv = ifv; v.e_ifd = ifd; v.e_dmv = dmv; v.e_dmd = dmd;
        v.e_sif = sif; v.e_smem = smem;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;

        // Lone fetch, then an ack while idle
        vq.push_back(mk(1'b1,1'b0,1'b0,1'b0, 32'h40,32'h0,32'h0,32'h0,        1'b1,1'b0,32'h40, 1'b0,32'h0,        1'b0,32'h0, 1'b1,1'b0));
        vq.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h40,32'h0,32'h0,32'h8C010004, 1'b0,1'b0,32'h40, 1'b1,32'h8C010004, 1'b0,32'h0, 1'b0,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b0, 32'h40,32'h0,32'h0,32'h0,        1'b0,1'b0,32'h40, 1'b0,32'h8C010004, 1'b0,32'h0, 1'b0,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b1, 32'h40,32'h0,32'h0,32'h1234,     1'b0,1'b0,32'h40, 1'b0,32'h8C010004, 1'b0,32'h0, 1'b0,1'b0));
        // Contention: data first, gap, then fetch
        vq.push_back(mk(1'b1,1'b1,1'b0,1'b0, 32'h44,32'h100,32'h0,32'h0,        1'b1,1'b0,32'h100, 1'b0,32'h8C010004, 1'b0,32'h0,        1'b1,1'b1));
        vq.push_back(mk(1'b1,1'b1,1'b0,1'b1, 32'h44,32'h100,32'h0,32'hAAAA5555, 1'b0,1'b0,32'h100, 1'b0,32'h8C010004, 1'b1,32'hAAAA5555, 1'b1,1'b0));
        vq.push_back(mk(1'b1,1'b0,1'b0,1'b0, 32'h44,32'h100,32'h0,32'h0,        1'b0,1'b0,32'h100, 1'b0,32'h8C010004, 1'b0,32'hAAAA5555, 1'b1,1'b0));
        vq.push_back(mk(1'b1,1'b0,1'b0,1'b0, 32'h44,32'h100,32'h0,32'h0,        1'b1,1'b0,32'h44,  1'b0,32'h8C010004, 1'b0,32'hAAAA5555, 1'b1,1'b0));
        vq.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h44,32'h100,32'h0,32'h11112222, 1'b0,1'b0,32'h44,  1'b1,32'h11112222, 1'b0,32'hAAAA5555, 1'b0,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b0, 32'h44,32'h100,32'h0,32'h0,        1'b0,1'b0,32'h44,  1'b0,32'h11112222, 1'b0,32'hAAAA5555, 1'b0,1'b0));
        // Starvation: three stores win, fourth grant goes to fetch
        for (int k = 0; k < 3; k++) begin
            vq.push_back(mk(1'b1,1'b0,1'b1,1'b0, 32'h48,32'h200,32'h5A5A0000,32'h0,        1'b1,1'b1,32'h200, 1'b0,32'h11112222, 1'b0,32'hAAAA5555, 1'b1,1'b1));
            vq.push_back(mk(1'b1,1'b0,1'b1,1'b1, 32'h48,32'h200,32'h5A5A0000,32'hFFFFFFFF, 1'b0,1'b1,32'h200, 1'b0,32'h11112222, 1'b1,32'hAAAA5555, 1'b1,1'b0));
            vq.push_back(mk(1'b1,1'b0,1'b1,1'b0, 32'h48,32'h200,32'h5A5A0000,32'h0,        1'b0,1'b1,32'h200, 1'b0,32'h11112222, 1'b0,32'hAAAA5555, 1'b1,1'b1));
        end
        vq.push_back(mk(1'b1,1'b0,1'b1,1'b0, 32'h48,32'h200,32'h5A5A0000,32'h0,        1'b1,1'b0,32'h48,  1'b0,32'h11112222, 1'b0,32'hAAAA5555, 1'b1,1'b1));
        vq.push_back(mk(1'b1,1'b0,1'b1,1'b1, 32'h48,32'h200,32'h5A5A0000,32'h22223333, 1'b0,1'b0,32'h48,  1'b1,32'h22223333, 1'b0,32'hAAAA5555, 1'b0,1'b1));
        vq.push_back(mk(1'b1,1'b0,1'b1,1'b0, 32'h4C,32'h200,32'h5A5A0000,32'h0,        1'b0,1'b0,32'h48,  1'b0,32'h22223333, 1'b0,32'hAAAA5555, 1'b1,1'b1));
        // Counter cleared by the fetch grant, so data wins again
        vq.push_back(mk(1'b1,1'b0,1'b1,1'b0, 32'h4C,32'h200,32'h5A5A0000,32'h0,        1'b1,1'b1,32'h200, 1'b0,32'h22223333, 1'b0,32'hAAAA5555, 1'b1,1'b1));
        vq.push_back(mk(1'b1,1'b0,1'b1,1'b1, 32'h4C,32'h200,32'h5A5A0000,32'h0,        1'b0,1'b1,32'h200, 1'b0,32'h22223333, 1'b1,32'hAAAA5555, 1'b1,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b0, 32'h4C,32'h200,32'h5A5A0000,32'h0,        1'b0,1'b1,32'h200, 1'b0,32'h22223333, 1'b0,32'hAAAA5555, 1'b0,1'b0));

        // Reset state
        step();
        chk("rst mem_req", mem_req, 32'h0);
        chk("rst mem_we", mem_we, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst if_valid", if_valid, 32'h0);
        chk("rst dm_valid", dm_valid, 32'h0);
        chk("rst if_rdata", if_rdata, 32'h0);
        chk("rst dm_rdata", dm_rdata, 32'h0);
        chk("rst err", err, 32'h0);
        reset = 1'b0;

        foreach (vq[i]) begin
            if_req = vq[i].i_ifr; MemRead = vq[i].i_rd; MemWrite = vq[i].i_wr;
            mem_ack = vq[i].i_ack; if_addr = vq[i].i_ifa; dm_addr = vq[i].i_dma;
            dm_wdata = vq[i].i_wd; mem_rdata = vq[i].i_rdata;
            step();
            chk($sformatf("v%0d mem_req", i),   mem_req,   vq[i].e_req);
            chk($sformatf("v%0d mem_we", i),    mem_we,    vq[i].e_we);
            chk($sformatf("v%0d mem_addr", i),  mem_addr,  vq[i].e_addr);
            chk($sformatf("v%0d if_valid", i),  if_valid,  vq[i].e_ifv);
            chk($sformatf("v%0d if_rdata", i),  if_rdata,  vq[i].e_ifd);
            chk($sformatf("v%0d dm_valid", i),  dm_valid,  vq[i].e_dmv);
            chk($sformatf("v%0d dm_rdata", i),  dm_rdata,  vq[i].e_dmd);
            chk($sformatf("v%0d stall_if", i),  stall_if,  vq[i].e_sif);
            chk($sformatf("v%0d stall_mem", i), stall_mem, vq[i].e_smem);
            chk($sformatf("v%0d err", i),       err,       32'h0);
        end

        // Timeout: load never acknowledged
        idle_inputs();
        MemRead = 1'b1; dm_addr = 32'h300; mem_rdata = 32'hCAFEF00D;
        step();
        chk("to grant mem_req", mem_req, 32'h1);
        chk("to grant mem_addr", mem_addr, 32'h300);
        chk("to grant mem_we", mem_we, 32'h0);
        for (int k = 1; k < 15; k++) begin
            step();
            chk($sformatf("to wait%0d dm_valid", k), dm_valid, 32'h0);
            chk($sformatf("to wait%0d mem_req", k), mem_req, 32'h1);
        end
        chk("to wait14 err", err, 32'h0);
        step();
        chk("to abort dm_valid", dm_valid, 32'h1);
        chk("to abort dm_rdata", dm_rdata, 32'h0);
        chk("to abort err", err, 32'h1);
        chk("to abort mem_req", mem_req, 32'h0);
        MemRead = 1'b0;
        step();
        chk("to after dm_valid", dm_valid, 32'h0);
        // err stays set across a later successful access
        if_req = 1'b1; if_addr = 32'h50;
        step();
        chk("to fetch mem_req", mem_req, 32'h1);
        mem_ack = 1'b1; mem_rdata = 32'h0000ABCD;
        step();
        chk("to fetch if_rdata", if_rdata, 32'h0000ABCD);
        chk("to sticky err", err, 32'h1);
        idle_inputs();
        step();
        chk("to sticky err2", err, 32'h1);

        // Reset in the middle of a data access
        MemRead = 1'b1; dm_addr = 32'h400;
        step();
        chk("ra grant mem_req", mem_req, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("ra async mem_req", mem_req, 32'h0);
        chk("ra async err", err, 32'h0);
        chk("ra async mem_addr", mem_addr, 32'h0);
        step();
        chk("ra held dm_valid", dm_valid, 32'h0);
        #2 reset = 1'b0;
        step();
        chk("ra regrant mem_req", mem_req, 32'h1);
        chk("ra regrant mem_addr", mem_addr, 32'h400);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        chk("ra done dm_valid", dm_valid, 32'h1);
        chk("ra done dm_rdata", dm_rdata, 32'h0BADF00D);
        chk("ra done err", err, 32'h0);
        idle_inputs();
        step();

        // Load and store together behave as a store
        MemRead = 1'b1; MemWrite = 1'b1; dm_addr = 32'h500; dm_wdata = 32'hDEADBEEF;
        step();
        chk("rw mem_req", mem_req, 32'h1);
        chk("rw mem_we", mem_we, 32'h1);
        chk("rw mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("rw mem_addr", mem_addr, 32'h500);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        step();
        chk("rw dm_valid", dm_valid, 32'h1);
        chk("rw dm_rdata", dm_rdata, 32'h0BADF00D);
        idle_inputs();
        step();
        chk("rw idle mem_req", mem_req, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters, one per line:
- DATA_W, 32, data and address width.
- WAIT_MAX, 15, mem_ack wait cycles before abort.
- STARVE_MAX, 3, consecutive data grants with if_req pending before instruction fetch wins.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch stage requests an instruction read.
- if_addr  in  DATA_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  one-cycle pulse; if_rdata valid.
- MemRead  in  1  MEM stage load.
- MemWrite  in  1  MEM stage store.
- dm_addr  in  DATA_W  data address (ALU result).
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data.
- dm_valid  out  1  one-cycle pulse; data access complete.
- mem_req  out  1  shared memory port request.
- mem_we  out  1  shared port write enable.
- mem_addr  out  DATA_W  shared port address.
- mem_wdata  out  DATA_W  shared port write data.
- mem_rdata  in  DATA_W  shared port read data.
- mem_ack  in  1  shared port completion, sampled on clk.
- stall_if  out  1  freeze PC and IF/ID.
- stall_mem  out  1  freeze the whole pipeline.
- err  out  1  sticky timeout flag.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, SERVE_IF and SERVE_DM.
REQ-004 In IDLE, a data request is (MemRead|MemWrite) & ~dm_valid and an instruction request is if_req & ~if_valid; requests masked by their own valid pulse SHALL be ignored.
REQ-005 When both requests are present in IDLE, data SHALL win unless starve_cnt == STARVE_MAX, in which case instruction fetch SHALL win.
REQ-006 starve_cnt SHALL increment (saturating at STARVE_MAX) on each data grant made while if_req is high, and SHALL clear on each IF grant.
REQ-007 On grant, the block SHALL register mem_addr, mem_wdata and mem_we.
- mem_we = MemWrite for data grants; MemWrite wins if MemRead and MemWrite are both high.
- mem_we = 0 for IF grants.
REQ-008 mem_req SHALL be high exactly while the state is SERVE_IF or SERVE_DM, and the registered mem_* signals SHALL be held stable throughout.
REQ-009 On the edge where mem_ack = 1 in SERVE_x, the block SHALL:
- capture mem_rdata into the matching rdata register (dm_rdata unchanged for stores);
- pulse the matching valid for the following cycle;
- return to IDLE.
REQ-010 Minimum latency SHALL be 2 cycles from a request to its valid pulse (grant edge, then ack edge); requests SHALL NOT be granted back to back without an intervening IDLE cycle.
REQ-011 wait_cnt SHALL clear on grant and increment each SERVE cycle without mem_ack. On reaching WAIT_MAX the block SHALL:
- set err;
- pulse the matching valid with rdata = 0;
- return to IDLE.
REQ-012 mem_ack seen in IDLE SHALL be ignored.
REQ-013 stall_if SHALL equal if_req & ~if_valid, and stall_mem SHALL equal (MemRead|MemWrite) & ~dm_valid; both are combinational.

Reset
REQ-014 Asserting reset SHALL immediately force:
- state IDLE;
- mem_req, mem_we, if_valid, dm_valid and err to 0;
- mem_addr, mem_wdata, if_rdata and dm_rdata to 0;
- starve_cnt and wait_cnt to 0.
REQ-015 Reset mid-transaction SHALL abandon the access with no valid pulse and no err.
REQ-016 err SHALL clear only on reset.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- Lone fetch: if_req=1, if_addr=0x40, mem_ack on the first SERVE cycle with rdata=0x8C010004 -> if_valid pulses at cycle 2 with if_rdata=0x8C010004, mem_we=0.
- Contention: if_req and MemRead high together, dm_addr=0x100 -> data served first (mem_addr=0x100), IF served next; stall_if stays high until if_valid.
- Starvation: MemWrite held high for 4 accesses with if_req high, STARVE_MAX=3 -> the 4th grant goes to IF, starve_cnt returns to 0.
- Timeout: MemRead, mem_ack held 0 -> after 15 SERVE cycles dm_valid pulses with dm_rdata=0, err=1 and held until reset.
- Reset mid-access: assert reset with mem_ack low in SERVE_DM -> mem_req=0 the same cycle, no dm_valid; after release a fresh request is served normally.
- Simultaneous MemRead and MemWrite, dm_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, dm_rdata unchanged.
